// File: rtl/pc_sequencer.sv
// Multicycle instruction sequencer: owns the PC, walks IF/ID/EXE/MEM/WB and commits one PC update per instruction.
// Optional build macro PC_ALIGN_CHECK_EN redirects misaligned commit targets to TRAP_PC and raises a sticky flag.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        imemAck,
    input  logic        instJump,
    input  logic        instJr,
    input  logic        instBranch,
    input  logic        instStore,
    input  logic        instLoad,
    input  logic        instHalt,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    input  logic [31:0] rsData,
    output logic [31:0] pc,
    output logic [1:0]  pcSrc,
    output logic        pcWrite,
    output logic        irWrite,
    output logic        imemReq,
    output logic [2:0]  state,
    output logic        halted,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXE  = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b101
    } state_t;

    localparam logic [1:0] SRC_PC4 = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_REG = 2'b10;
    localparam logic [1:0] SRC_JMP = 2'b11;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic        br_r;
    logic        st_r;
    logic        ld_r;
    logic        commit_s;
    logic        irw_s;
    logic        req_s;
    logic [1:0]  src_s;
    logic [31:0] pc4_s;
    logic [31:0] br_tgt_s;
    logic [31:0] jmp_tgt_s;
    logic [31:0] tgt_s;

    assign pc4_s     = pc_r + 32'd4;
    assign br_tgt_s  = pc4_s + {{14{imm16[15]}}, imm16, 2'b00};
    assign jmp_tgt_s = {pc4_s[31:28], addr26, 2'b00};

    // State register, PC register and the instruction class captured in ID.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= ST_IF;
            pc_r    <= RESET_PC;
            br_r    <= 1'b0;
            st_r    <= 1'b0;
            ld_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (commit_s) begin
                pc_r <= pc_nxt_s;
            end else begin
                pc_r <= pc_r;
            end
            // Branch outranks store, store outranks load; ALU is none of them.
            if (state_r == ST_ID) begin
                br_r <= instBranch;
                st_r <= ~instBranch & instStore;
                ld_r <= ~instBranch & ~instStore & instLoad;
            end else begin
                br_r <= br_r;
                st_r <= st_r;
                ld_r <= ld_r;
            end
        end
    end

    // Next-state decode and the per-state strobes.
    always_comb begin
        state_nxt_s = state_r;
        commit_s    = 1'b0;
        irw_s       = 1'b0;
        req_s       = 1'b0;
        src_s       = SRC_PC4;
        case (state_r)
            ST_IF: begin
                req_s = 1'b1;
                if (imemAck) begin
                    irw_s       = 1'b1;
                    state_nxt_s = ST_ID;
                end else begin
                    state_nxt_s = ST_IF;
                end
            end
            ST_ID: begin
                if (instHalt) begin
                    state_nxt_s = ST_HALT;
                end else if (instJr) begin
                    commit_s    = 1'b1;
                    src_s       = SRC_REG;
                    state_nxt_s = ST_IF;
                end else if (instJump) begin
                    commit_s    = 1'b1;
                    src_s       = SRC_JMP;
                    state_nxt_s = ST_IF;
                end else begin
                    state_nxt_s = ST_EXE;
                end
            end
            ST_EXE: begin
                if (br_r) begin
                    commit_s    = 1'b1;
                    src_s       = zero ? SRC_BR : SRC_PC4;
                    state_nxt_s = ST_IF;
                end else if (st_r || ld_r) begin
                    state_nxt_s = ST_MEM;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (st_r) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IF;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_WB: begin
                commit_s    = 1'b1;
                state_nxt_s = ST_IF;
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IF;
            end
        endcase
    end

    // Commit target selection.
    always_comb begin
        tgt_s = pc4_s;
        case (src_s)
            SRC_PC4: tgt_s = pc4_s;
            SRC_BR:  tgt_s = br_tgt_s;
            SRC_REG: tgt_s = rsData;
            SRC_JMP: tgt_s = jmp_tgt_s;
            default: tgt_s = pc4_s;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_r;
    logic trap_s;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    // A misaligned target is replaced by the trap vector.
    always_comb begin
        trap_s = commit_s & is_misaligned(tgt_s[1:0]);
        if (trap_s) begin
            pc_nxt_s = TRAP_PC;
        end else begin
            pc_nxt_s = tgt_s;
        end
    end

    // Sticky misaligned flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            misaligned_r <= 1'b0;
        end else if (trap_s) begin
            misaligned_r <= 1'b1;
        end else begin
            misaligned_r <= misaligned_r;
        end
    end

    assign misaligned = misaligned_r;
`else
    // Targets are written unmodified.
    always_comb begin
        pc_nxt_s = tgt_s;
    end

    assign misaligned = 1'b0;
`endif

    // Strobes are held off while reset is applied so no partial fetch or commit escapes.
    assign pcWrite = commit_s & RST_n;
    assign irWrite = irw_s & RST_n;
    assign imemReq = req_s & RST_n;
    assign pcSrc   = src_s;
    assign pc      = pc_r;
    assign state   = state_r;
    assign halted  = (state_r == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a driver pushes expected commits into a queue, a negedge monitor pops and compares them.
module tb_pc_sequencer;

    localparam int K_ALU  = 0;
    localparam int K_BR   = 1;
    localparam int K_J    = 2;
    localparam int K_JR   = 3;
    localparam int K_LD   = 4;
    localparam int K_ST   = 5;
    localparam int K_HALT = 6;

    typedef struct packed {
        logic [31:0] lat;
        logic [1:0]  src;
        logic [31:0] pc;
        logic [2:0]  st;
        logic        mis;
    } exp_t;

    logic        CLK;
    logic        RST_n;
    logic        imemAck;
    logic        instJump;
    logic        instJr;
    logic        instBranch;
    logic        instStore;
    logic        instLoad;
    logic        instHalt;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [31:0] rsData;
    logic [31:0] pc;
    logic [1:0]  pcSrc;
    logic        pcWrite;
    logic        irWrite;
    logic        imemReq;
    logic [2:0]  state;
    logic        halted;
    logic        misaligned;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    logic [31:0] mpc      = 32'h0000_0000;
    logic        mis_model = 1'b0;
    int          cyc      = 0;
    logic        pc_pend  = 1'b0;
    exp_t        pend_e;

    pc_sequencer dut (
        .CLK(CLK), .RST_n(RST_n), .imemAck(imemAck),
        .instJump(instJump), .instJr(instJr), .instBranch(instBranch),
        .instStore(instStore), .instLoad(instLoad), .instHalt(instHalt),
        .zero(zero), .imm16(imm16), .addr26(addr26), .rsData(rsData),
        .pc(pc), .pcSrc(pcSrc), .pcWrite(pcWrite), .irWrite(irWrite),
        .imemReq(imemReq), .state(state), .halted(halted), .misaligned(misaligned)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Monitor: counts cycles from the acked fetch and scores every commit against the queue.
    always @(negedge CLK) begin
        automatic int   c;
        automatic exp_t e;
        if (pc_pend) begin
            check_eq("pc_after_commit", pc, pend_e.pc);
            check_eq("misaligned", {31'd0, misaligned}, {31'd0, pend_e.mis});
        end
        if (imemReq && imemAck) c = 1;
        else c = cyc + 1;
        if (pcWrite) begin
            check_eq("commit_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("latency", c, e.lat);
                check_eq("pcSrc", {30'd0, pcSrc}, {30'd0, e.src});
                check_eq("commit_state", {29'd0, state}, {29'd0, e.st});
                pend_e  <= e;
                pc_pend <= 1'b1;
            end else begin
                pc_pend <= 1'b0;
            end
        end else begin
            pc_pend <= 1'b0;
        end
        cyc <= c;
    end

    task automatic clear_flags();
        instJump = 1'b0; instJr = 1'b0; instBranch = 1'b0;
        instStore = 1'b0; instLoad = 1'b0; instHalt = 1'b0;
    endtask

    // Runs one instruction from IF; caller is in IF, a couple of ns after a rising edge.
    task automatic exec(input int kind, input logic [15:0] i16, input logic [25:0] a26,
                        input logic [31:0] rs, input logic z, input int stall);
        exp_t        e;
        logic [31:0] pc4;
        logic [31:0] tgt;
        int          n;
        pc4   = mpc + 32'd4;
        e.mis = mis_model;
        tgt   = pc4;
        e.src = 2'b00;
        case (kind)
            K_BR: begin
                e.lat = 32'd3; e.st = 3'd2;
                e.src = z ? 2'b01 : 2'b00;
                tgt   = z ? pc4 + {{14{i16[15]}}, i16, 2'b00} : pc4;
            end
            K_J:  begin e.lat = 32'd2; e.st = 3'd1; e.src = 2'b11; tgt = {pc4[31:28], a26, 2'b00}; end
            K_JR: begin e.lat = 32'd2; e.st = 3'd1; e.src = 2'b10; tgt = rs; end
            K_LD: begin e.lat = 32'd5; e.st = 3'd4; end
            K_ST: begin e.lat = 32'd4; e.st = 3'd3; end
            default: begin e.lat = 32'd4; e.st = 3'd4; end
        endcase
`ifdef PC_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) begin
            tgt   = 32'h0000_0080;
            e.mis = 1'b1;
        end
`endif
        e.pc = tgt;
        imm16 = i16; addr26 = a26; rsData = rs; zero = z;
        clear_flags();
        // Lower-priority classes are raised alongside to exercise decode priority.
        case (kind)
            K_BR:   begin instBranch = 1'b1; instStore = 1'b1; end
            K_J:    begin instJump = 1'b1; instBranch = 1'b1; instLoad = 1'b1; end
            K_JR:   begin instJr = 1'b1; instJump = 1'b1; instBranch = 1'b1; end
            K_LD:   instLoad = 1'b1;
            K_ST:   instStore = 1'b1;
            K_HALT: begin instHalt = 1'b1; instJr = 1'b1; instJump = 1'b1; end
            default: ;
        endcase
        for (int i = 0; i < stall; i++) begin
            imemAck = 1'b0;
            check_eq("stall_state", {29'd0, state}, 32'd0);
            check_eq("stall_req", {31'd0, imemReq}, 32'd1);
            check_eq("stall_irwrite", {31'd0, irWrite}, 32'd0);
            check_eq("stall_pc", pc, mpc);
            @(posedge CLK); #2;
        end
        if (kind != K_HALT) exp_q.push_back(e);
        imemAck = 1'b1;
        #1;
        check_eq("irwrite_ack", {31'd0, irWrite}, 32'd1);
        @(posedge CLK); #1;
        imemAck = 1'b0;
        #1;
        check_eq("id_state", {29'd0, state}, 32'd1);
        check_eq("irwrite_id", {31'd0, irWrite}, 32'd0);
        if (kind == K_HALT) begin
            @(posedge CLK); #2;
            check_eq("halt_state", {29'd0, state}, 32'd5);
            check_eq("halted", {31'd0, halted}, 32'd1);
            imemAck = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge CLK); #2;
                check_eq("halt_req", {31'd0, imemReq}, 32'd0);
                check_eq("halt_hold", {29'd0, state}, 32'd5);
            end
            check_eq("halt_pc", pc, mpc);
            imemAck = 1'b0;
        end else begin
            n = 0;
            while (state != 3'd0 && n < 8) begin
                @(posedge CLK); #2;
                n++;
            end
            check_eq("return_if", {29'd0, state}, 32'd0);
            mpc       = e.pc;
            mis_model = e.mis;
        end
        clear_flags();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST_n = 1'b0; imemAck = 1'b1; zero = 1'b0;
        imm16 = 16'h0000; addr26 = 26'h0; rsData = 32'h0;
        clear_flags();
        #3;
        check_eq("rst_pc", pc, 32'h0000_0000);
        check_eq("rst_state", {29'd0, state}, 32'd0);
        check_eq("rst_req", {31'd0, imemReq}, 32'd0);
        check_eq("rst_irwrite", {31'd0, irWrite}, 32'd0);
        check_eq("rst_pcwrite", {31'd0, pcWrite}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_misaligned", {31'd0, misaligned}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1; imemAck = 1'b0;
        @(posedge CLK); #2;

        exec(K_JR, 16'h0, 26'h0, 32'h0000_0100, 1'b0, 3);
        exec(K_ALU, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        exec(K_JR, 16'h0, 26'h0, 32'h0000_0100, 1'b0, 0);
        exec(K_BR, 16'hFFFE, 26'h0, 32'h0, 1'b1, 0);
        exec(K_JR, 16'h0, 26'h0, 32'h0000_0100, 1'b0, 0);
        exec(K_BR, 16'hFFFE, 26'h0, 32'h0, 1'b0, 0);
        exec(K_JR, 16'h0, 26'h0, 32'h3000_0010, 1'b0, 0);
        exec(K_J, 16'h0, 26'h000_0040, 32'h0, 1'b0, 0);
        exec(K_JR, 16'h0, 26'h0, 32'h0000_2000, 1'b0, 0);
        exec(K_LD, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        exec(K_ST, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        exec(K_JR, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, 1);
        exec(K_BR, 16'h7FFF, 26'h0, 32'h0, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] r;
            r = $urandom;
            r[1:0] = 2'b00;
            exec($urandom_range(0, 5), 16'($urandom), 26'($urandom), r,
                 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Reset pulse while a load sits in MEM: the instruction must vanish.
        instLoad = 1'b1; imemAck = 1'b1;
        @(posedge CLK); #1 imemAck = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #2;
        check_eq("mem_state", {29'd0, state}, 32'd3);
        RST_n = 1'b0;
        #1;
        check_eq("abort_pc", pc, 32'h0000_0000);
        check_eq("abort_state", {29'd0, state}, 32'd0);
        check_eq("abort_req", {31'd0, imemReq}, 32'd0);
        check_eq("abort_pcwrite", {31'd0, pcWrite}, 32'd0);
        mpc = 32'h0000_0000; mis_model = 1'b0;
        @(posedge CLK); #3;
        RST_n = 1'b1;
        clear_flags();
        check_eq("abort_queue", exp_q.size(), 32'd0);

        exec(K_JR, 16'h0, 26'h0, 32'h0000_2002, 1'b0, 0);
        exec(K_ALU, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        exec(K_HALT, 16'h0, 26'h0, 32'h0, 1'b0, 0);

        @(negedge CLK);
        @(negedge CLK);
        check_eq("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
